// File: rtl/fft_pkg.sv
// Shared types and constants for the in-place radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EN,
        CALC,
        WR,
        FIN
    } state_t;

    localparam int unsigned BFLY_CYCLES = 4;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational operand/twiddle address generator for butterfly k of stage s.
module fft_addr_gen #(
    parameter int unsigned LOG2N = 4,
    parameter int unsigned TF_AW = LOG2N - 1
) (
    input  logic [LOG2N-1:0] s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TF_AW-1:0] tf_addr
);

    localparam int unsigned AW = LOG2N;

    logic [AW-1:0] span;
    logic [AW-1:0] pos;
    logic [AW-1:0] grp;
    logic [AW-1:0] shamt;

    // Pairs sit span apart inside groups of 2*span; twiddle stride shrinks as span grows.
    always_comb begin
        span    = AW'(1) << s;
        pos     = AW'(k) & (span - AW'(1));
        grp     = AW'(k) >> s;
        addr_a  = (grp << (s + AW'(1))) | pos;
        addr_b  = addr_a + span;
        shamt   = AW'(LOG2N - 1) - s;
        tf_addr = TF_AW'(pos << shamt);
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// Butterfly scheduler: RD/EN/CALC/WR per butterfly across all stages of an in-place FFT.
// Optional busy-cycle counter output cyc_cnt when FFT_BFLY_SCHED_CYCCNT_EN is defined.
module fft_bfly_sched #(
    parameter int unsigned LOG2N = 4,
    parameter int unsigned TF_AW = LOG2N - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] mem_addr_a,
    output logic [LOG2N-1:0] mem_addr_b,
    output logic             mem_re,
    output logic             mem_we,
    output logic [TF_AW-1:0] tf_addr,
    output logic             bf_enable,
    output logic [LOG2N-1:0] stage
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
    ,
    output logic [31:0]      cyc_cnt
`endif
);

    import fft_pkg::*;

    localparam int unsigned KW = LOG2N - 1;
    localparam logic [KW-1:0] K_MAX = '1;

    state_t           state;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_inc;
    logic [LOG2N-1:0] s_inc;
    logic [LOG2N-1:0] gen_s;
    logic [KW-1:0]    gen_k;
    logic             last_c;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [TF_AW-1:0] gen_tf;

    // Leaving WR the addresses must already describe the next butterfly.
    always_comb begin
        last_c = (stage == LOG2N'(LOG2N - 1)) && (k == K_MAX);
        k_inc  = k + KW'(1);
        s_inc  = stage;
        if (k == K_MAX) begin
            s_inc = stage + LOG2N'(1);
        end
        gen_s = stage;
        gen_k = k;
        if (state == WR) begin
            gen_s = s_inc;
            gen_k = k_inc;
        end
    end

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .TF_AW (TF_AW)
    ) u_addr_gen (
        .s       (gen_s),
        .k       (gen_k),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tf_addr (gen_tf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            stage      <= '0;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            bf_enable  <= 1'b0;
            mem_addr_a <= '0;
            mem_addr_b <= '0;
            tf_addr    <= '0;
        end else begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            bf_enable <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RD;
                        stage      <= '0;
                        k          <= '0;
                        busy       <= 1'b1;
                        mem_re     <= 1'b1;
                        mem_addr_a <= gen_a;
                        mem_addr_b <= gen_b;
                        tf_addr    <= gen_tf;
                    end
                end
                RD: begin
                    state     <= EN;
                    bf_enable <= 1'b1;
                end
                EN: begin
                    state <= CALC;
                end
                CALC: begin
                    state  <= WR;
                    mem_we <= 1'b1;
                end
                WR: begin
                    if (last_c) begin
                        state      <= FIN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        stage      <= '0;
                        k          <= '0;
                        mem_addr_a <= '0;
                        mem_addr_b <= '0;
                        tf_addr    <= '0;
                    end else begin
                        state      <= RD;
                        stage      <= s_inc;
                        k          <= k_inc;
                        mem_re     <= 1'b1;
                        mem_addr_a <= gen_a;
                        mem_addr_b <= gen_b;
                        tf_addr    <= gen_tf;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FFT_BFLY_SCHED_CYCCNT_EN
    // Counts cycles spent busy in the current run; holds once the run completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scoreboard bench for fft_bfly_sched (N=16) with a closed-loop RAM/ROM/butterfly model.
module tb_fft_bfly_sched;

    localparam int LOG2N   = 4;
    localparam int N       = 16;
    localparam int HALF    = 8;
    localparam int TF_AW   = 3;
    localparam int RUN_CYC = 128;
    localparam logic signed [31:0] IMP = 32'sh4000_0000;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] mem_addr_a;
    logic [LOG2N-1:0] mem_addr_b;
    logic             mem_re;
    logic             mem_we;
    logic [TF_AW-1:0] tf_addr;
    logic             bf_enable;
    logic [LOG2N-1:0] stage;
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
    logic [31:0]      cyc_cnt;
`endif

    always #5 clock = ~clock;

    fft_bfly_sched #(
        .LOG2N (LOG2N),
        .TF_AW (TF_AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .tf_addr    (tf_addr),
        .bf_enable  (bf_enable),
        .stage      (stage)
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
        ,
        .cyc_cnt    (cyc_cnt)
`endif
    );

    int n_chk    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int a;
        int b;
        int tf;
        int s;
    } exp_t;

    exp_t sb[$];

    // Expected butterfly sequence in plain integer arithmetic.
    task automatic fill_sb();
        exp_t e;
        for (int s = 0; s < LOG2N; s++) begin
            int span;
            span = 1 << s;
            for (int k = 0; k < HALF; k++) begin
                e.a  = (k / span) * 2 * span + (k % span);
                e.b  = e.a + span;
                e.tf = (k % span) * (N / (2 * span));
                e.s  = s;
                sb.push_back(e);
            end
        end
    endtask

    // Data RAM, twiddle ROM and butterfly model driven by the DUT strobes.
    logic signed [31:0] ram_re [N];
    logic signed [31:0] ram_im [N];
    logic signed [31:0] tw_re  [HALF];
    logic signed [31:0] tw_im  [HALF];
    logic signed [31:0] da_re, da_im, db_re, db_im;
    logic signed [31:0] y_re, y_im, z_re, z_im;
    logic [TF_AW-1:0]   tw_i;
    logic               ram_clear = 1'b0;
    logic signed [63:0] t_re, t_im;

    assign t_re = (64'(db_re) * 64'(tw_re[tw_i]) - 64'(db_im) * 64'(tw_im[tw_i])) >>> 30;
    assign t_im = (64'(db_re) * 64'(tw_im[tw_i]) + 64'(db_im) * 64'(tw_re[tw_i])) >>> 30;

    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < N; i++) begin
                ram_re[i] <= '0;
                ram_im[i] <= '0;
            end
            ram_re[0] <= IMP;
        end else begin
            if (mem_re) begin
                da_re <= ram_re[mem_addr_a];
                da_im <= ram_im[mem_addr_a];
                db_re <= ram_re[mem_addr_b];
                db_im <= ram_im[mem_addr_b];
                tw_i  <= tf_addr;
            end
            if (bf_enable) begin
                y_re <= da_re + 32'(t_re);
                y_im <= da_im + 32'(t_im);
                z_re <= da_re - 32'(t_re);
                z_im <= da_im - 32'(t_im);
            end
            if (mem_we) begin
                ram_re[mem_addr_a] <= y_re;
                ram_im[mem_addr_a] <= y_im;
                ram_re[mem_addr_b] <= z_re;
                ram_im[mem_addr_b] <= z_im;
            end
        end
    end

    // Protocol monitor: pops one expected butterfly per RD and tracks its four phases.
    initial begin
        int   ph;
        exp_t e;
        ph = 0;
        e  = '{0, 0, 0, 0};
        forever begin
            @(negedge clock);
            if (reset) begin
                ph = 0;
            end else begin
                if (done) done_cnt++;
                case (ph)
                    0: begin
                        if (mem_re) begin
                            if (sb.size() == 0) begin
                                chk("sb_underflow", 64'd1, 64'd0);
                            end else begin
                                e = sb.pop_front();
                                chk("rd_addr_a", 64'(mem_addr_a), 64'(e.a));
                                chk("rd_addr_b", 64'(mem_addr_b), 64'(e.b));
                                chk("rd_tf",     64'(tf_addr),    64'(e.tf));
                                chk("rd_stage",  64'(stage),      64'(e.s));
                            end
                            chk("rd_strobes", 64'({bf_enable, mem_we}), 64'd0);
                            ph = 1;
                        end else begin
                            chk("idle_strobes", 64'({bf_enable, mem_we}), 64'd0);
                        end
                    end
                    1: begin
                        chk("en_strobes", 64'({mem_re, bf_enable, mem_we}), 64'b010);
                        chk("en_addr_a", 64'(mem_addr_a), 64'(e.a));
                        ph = 2;
                    end
                    2: begin
                        chk("calc_strobes", 64'({mem_re, bf_enable, mem_we}), 64'b000);
                        chk("calc_addr_b", 64'(mem_addr_b), 64'(e.b));
                        chk("calc_tf", 64'(tf_addr), 64'(e.tf));
                        ph = 3;
                    end
                    default: begin
                        chk("wr_strobes", 64'({mem_re, bf_enable, mem_we}), 64'b001);
                        chk("wr_addr_a", 64'(mem_addr_a), 64'(e.a));
                        chk("wr_addr_b", 64'(mem_addr_b), 64'(e.b));
                        chk("wr_busy", 64'(busy), 64'd1);
                        ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic run(input bit hold);
        int busy_n;
        bit seen;
        int d0;
        fill_sb();
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clock);
        chk("busy_after_start", 64'(busy), 64'd1);
        if (!hold) start = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clock);
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(busy_n), 64'(RUN_CYC));
        chk("busy_in_done", 64'(busy), 64'd0);
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
        chk("cyc_cnt_done", 64'(cyc_cnt), 64'(RUN_CYC));
`endif
        @(negedge clock);
        chk("done_pulse", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_outputs", 64'({mem_addr_a, mem_addr_b, tf_addr, stage}), 64'd0);
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
        chk("cyc_cnt_hold", 64'(cyc_cnt), 64'(RUN_CYC));
`endif
        start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("no_requeue", 64'(busy), 64'd0);
        end
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < HALF; i++) begin
            tw_re[i] = $rtoi($cos(6.283185307179586 * i / N) * 1073741824.0);
            tw_im[i] = -$rtoi($sin(6.283185307179586 * i / N) * 1073741824.0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", 64'({busy, done, mem_re, mem_we, bf_enable,
                                mem_addr_a, mem_addr_b, tf_addr, stage}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_after_rst", 64'({busy, done, mem_re, mem_we, bf_enable, stage}), 64'd0);

        // Impulse at x[0] must spread to every bin unchanged.
        ram_clear = 1'b1;
        @(negedge clock);
        ram_clear = 1'b0;
        run(1'b0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bin%0d_re", i), 64'(ram_re[i]), 64'(IMP));
            chk($sformatf("bin%0d_im", i), 64'(ram_im[i]), 64'd0);
        end

        // Abort at busy cycle 40, then reset together with start.
        fill_sb();
        d0    = done_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (39) @(negedge clock);
        chk("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_outputs", 64'({busy, done, mem_re, mem_we, bf_enable,
                                  mem_addr_a, mem_addr_b, tf_addr, stage}), 64'd0);
        start = 1'b1;
        @(negedge clock);
        chk("rst_start_idle", 64'({busy, done, mem_re}), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        sb.delete();
        repeat (5) @(negedge clock);
        chk("abort_stays_idle", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
`ifdef FFT_BFLY_SCHED_CYCCNT_EN
        chk("cyc_cnt_rst", 64'(cyc_cnt), 64'd0);
`endif

        run(1'b0);
        run(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
